// File: rtl/csr_access_ctrl.sv
// CSR access sequencer: Zicsr read-modify-write ops and the trap entry sequence.
// Optional macro CSR_ILLEGAL_TRAP_EN: an illegal CSR write also enters the trap sequence.
module csr_access_ctrl #(
    parameter logic [11:0] MEPC_ADDR     = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR   = 12'h342,
    parameter logic [11:0] MTVEC_ADDR    = 12'h305,
    parameter logic [31:0] ILLEGAL_CAUSE = 32'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_csr,
    input  logic [31:0] req_rs1_data,
    input  logic        req_rs1_zero,
    input  logic        req_rd_zero,
    input  logic [4:0]  req_zimm,
    input  logic [31:0] req_pc,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    output logic        csr_read_en,
    output logic [11:0] csr_addr,
    input  logic [31:0] csr_rdata,
    output logic        csr_write_en,
    output logic [11:0] csr_wb_addr,
    output logic [31:0] csr_wb_data,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_illegal,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, RD, WR, RESP, T_EPC, T_CAUSE, T_VEC
    } state_t;

    state_t      state, next_state;
    logic [2:0]  f3_q;
    logic [11:0] addr_q;
    logic [31:0] op_q;
    logic        rs1_zero_q;
    logic        rd_zero_q;
    logic [31:0] old_q;
    logic        illegal_q;
    logic [31:0] tpc_q;
    logic [31:0] tcause_q;

    logic        is_rw;
    logic        wr_req;
    logic        illegal_w;
    logic [31:0] new_val;
    logic        read_skip;

`ifdef CSR_ILLEGAL_TRAP_EN
    logic [31:0] pc_q;
`else
    logic        unused_cfg;
    assign unused_cfg = ^{req_pc, ILLEGAL_CAUSE};
`endif

    assign is_rw     = (f3_q[1:0] == 2'b01);
    assign read_skip = is_rw && rd_zero_q;
    // Set/clear with a zero source never writes, so it cannot be illegal either.
    assign wr_req    = !(!is_rw && rs1_zero_q);
    assign illegal_w = wr_req && (addr_q[11:10] == 2'b11);

    always_comb begin
        case (f3_q[1:0])
            2'b10:   new_val = old_q | op_q;
            2'b11:   new_val = old_q & ~op_q;
            default: new_val = op_q;
        endcase
    end

    assign req_ready = (state == IDLE) && !trap_valid;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            f3_q       <= '0;
            addr_q     <= '0;
            op_q       <= '0;
            rs1_zero_q <= 1'b0;
            rd_zero_q  <= 1'b0;
            old_q      <= '0;
            illegal_q  <= 1'b0;
            tpc_q      <= '0;
            tcause_q   <= '0;
`ifdef CSR_ILLEGAL_TRAP_EN
            pc_q       <= '0;
`endif
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (trap_valid) begin
                        tpc_q    <= trap_pc;
                        tcause_q <= trap_cause;
                    end else if (req_valid) begin
                        f3_q       <= req_funct3;
                        addr_q     <= req_csr;
                        op_q       <= req_funct3[2] ? {27'b0, req_zimm} : req_rs1_data;
                        rs1_zero_q <= req_rs1_zero;
                        rd_zero_q  <= req_rd_zero;
                        illegal_q  <= 1'b0;
`ifdef CSR_ILLEGAL_TRAP_EN
                        pc_q       <= req_pc;
`endif
                    end
                end
                RD:   old_q     <= read_skip ? '0 : csr_rdata;
                WR:   illegal_q <= illegal_w;
`ifdef CSR_ILLEGAL_TRAP_EN
                RESP: begin
                    if (illegal_q) begin
                        tpc_q    <= pc_q;
                        tcause_q <= ILLEGAL_CAUSE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state     = state;
        csr_read_en    = 1'b0;
        csr_addr       = '0;
        csr_write_en   = 1'b0;
        csr_wb_addr    = '0;
        csr_wb_data    = '0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        resp_illegal   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            IDLE: begin
                if (trap_valid)     next_state = T_EPC;
                else if (req_valid) next_state = RD;
            end
            RD: begin
                if (!read_skip) begin
                    csr_read_en = 1'b1;
                    csr_addr    = addr_q;
                end
                next_state = WR;
            end
            WR: begin
                if (wr_req && !illegal_w && !rst) begin
                    csr_write_en = 1'b1;
                    csr_wb_addr  = addr_q;
                    csr_wb_data  = new_val;
                end
                next_state = RESP;
            end
            RESP: begin
                resp_valid   = 1'b1;
                resp_rdata   = old_q;
                resp_illegal = illegal_q;
`ifdef CSR_ILLEGAL_TRAP_EN
                next_state   = illegal_q ? T_EPC : IDLE;
`else
                next_state   = IDLE;
`endif
            end
            T_EPC: begin
                if (!rst) begin
                    csr_write_en = 1'b1;
                    csr_wb_addr  = MEPC_ADDR;
                    csr_wb_data  = tpc_q & ~32'h3;
                end
                next_state = T_CAUSE;
            end
            T_CAUSE: begin
                if (!rst) begin
                    csr_write_en = 1'b1;
                    csr_wb_addr  = MCAUSE_ADDR;
                    csr_wb_data  = tcause_q;
                end
                next_state = T_VEC;
            end
            T_VEC: begin
                csr_read_en    = 1'b1;
                csr_addr       = MTVEC_ADDR;
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata & ~32'h3;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Sequences all accesses to the 32-entry CSR file for the RV32I core: Zicsr read-modify-write ops (CSRRW/S/C and immediate forms) and the trap entry sequence (mepc, then mcause, then mtvec read).
- Sits between the EX stage and the CSR file. Drives the file's read and write ports; stalls the pipeline while busy.
- Only master of the CSR file ports.

Parameters:
- MEPC_ADDR, 12'h341, CSR address written with the trap PC
- MCAUSE_ADDR, 12'h342, CSR address written with the trap cause
- MTVEC_ADDR, 12'h305, CSR address read for the trap vector
- ILLEGAL_CAUSE, 32'd2, mcause value for an illegal CSR write

Ports:
- clk  in  1  clock; sole clock domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CSR instruction request from EX
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- req_csr  in  12  CSR address
- req_rs1_data  in  32  register operand
- req_rs1_zero  in  1  rs1 field (or zimm) is zero
- req_rd_zero  in  1  rd field is x0
- req_zimm  in  5  immediate operand, zero-extended
- req_pc  in  32  PC of the CSR instruction
- trap_valid  in  1  trap request (ecall/exception)
- trap_pc  in  32  faulting PC
- trap_cause  in  32  cause code
- csr_read_en  out  1  to CSR file read_en
- csr_addr  out  12  to CSR file read address
- csr_rdata  in  32  combinational read data from CSR file
- csr_write_en  out  1  to CSR file write_en
- csr_wb_addr  out  12  to CSR file write address
- csr_wb_data  out  32  to CSR file write data
- resp_valid  out  1  one-cycle pulse: op complete
- resp_rdata  out  32  old CSR value for rd
- resp_illegal  out  1  valid with resp_valid; write to read-only CSR
- redirect_valid  out  1  one-cycle pulse: fetch from redirect_pc
- redirect_pc  out  32  mtvec & ~32'h3
- busy  out  1  high in every state except IDLE; pipeline stall

Behaviour:
- Reset (sync, rst high at posedge): state IDLE; all registered outputs and captured operands 0. In-flight sequence aborts. No write is issued in the reset cycle.
- req_ready = (state==IDLE) && !trap_valid. Trap has priority over a simultaneous req_valid; that request is not accepted.
- States: IDLE, RD, WR, RESP, T_EPC, T_CAUSE, T_VEC.
- CSR op path:
  - IDLE --accept--> RD: register funct3, addr, operand. Operand = rs1_data, or {27'b0, zimm} for funct3[2]=1.
  - RD: csr_read_en=1, csr_addr=addr; capture csr_rdata into old_q. Exception: RW/RWI with req_rd_zero drives read_en=0 and old_q=0.
  - RD -> WR: new value is RW=op, RS=old|op, RC=old&~op.
  - WR: csr_write_en=1 except (a) RS/RC/RSI/RCI with req_rs1_zero; (b) addr[11:10]==2'b11 and a write would occur (sets illegal_q, no write).
  - WR -> RESP. RESP: resp_valid=1, resp_rdata=old_q, resp_illegal=illegal_q. RESP -> IDLE.
  - Latency: accept at cycle 0, resp_valid at cycle 3; next accept at cycle 4 earliest.
- Trap path:
  - IDLE & trap_valid -> T_EPC: write MEPC_ADDR = trap_pc & ~32'h3.
  - T_CAUSE: write MCAUSE_ADDR = trap_cause.
  - T_VEC: read MTVEC_ADDR; redirect_valid=1, redirect_pc=csr_rdata & ~32'h3. T_VEC -> IDLE.
  - trap_valid is ignored outside IDLE; the upstream holds it until it is accepted.
- Port drive:
  - Only one of csr_read_en/csr_write_en is high per cycle.
  - Inactive cycles drive addr/data 0.
  - The file commits writes on the falling edge, so a write in WR is visible to a read in the following cycle.
- Widths: all arithmetic 32-bit, no carries; addresses passed as full 12 bits.

Optional Feature:
- Macro CSR_ILLEGAL_TRAP_EN.
- Defined: an illegal write (case b) gives RESP with resp_illegal=1. RESP then goes directly to T_EPC with trap_pc=req_pc (registered) and trap_cause=ILLEGAL_CAUSE instead of returning to IDLE; busy stays high throughout.
- Undefined: illegal writes are only flagged through resp_illegal; RESP -> IDLE.

Test Plan:
- CSRRW x5, 0x300 with rs1=0xDEADBEEF and mstatus=0x8 -> read at cycle 1, write 0xDEADBEEF at cycle 2, resp_valid at cycle 3 with rdata 0x8.
- CSRRS addr 0x340, rs1=0x00F0 over old 0x0F00 -> write 0x0FF0. Repeat with req_rs1_zero=1 -> csr_write_en never asserts, rdata 0x0FF0.
- CSRRCI addr 0x340 zimm=5'b00011 over old 0x0007 -> write 0x0004.
- trap_valid with pc=0x1002, cause=11, mtvec=0x80000001 -> mepc=0x1000, mcause=11, redirect_pc=0x80000000 at cycle 3.
- trap_valid and req_valid in the same cycle -> req_ready=0, trap sequence runs, request accepted in the cycle after T_VEC.
- CSRRW to 0xC00 at req_pc 0x200 -> no write, resp_illegal=1. With CSR_ILLEGAL_TRAP_EN: mepc=0x200, mcause=2 follow. Assert rst during WR -> no write, busy=0 next cycle.
